// File: rtl/regfile_wb_if.sv
// Writeback port bundle: ALU and load/mul result sources, hazard queries,
// and the single regfile write port.
interface regfile_wb_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          alu_valid;
    logic [AW-1:0] alu_rd_addr;
    logic [DW-1:0] alu_data;

    logic          lsu_valid;
    logic          lsu_ready;
    logic [AW-1:0] lsu_rd_addr;
    logic [DW-1:0] lsu_data;

    logic [AW-1:0] q_addr1;
    logic [AW-1:0] q_addr2;
    logic          pend1;
    logic          pend2;

    logic [CW-1:0] fifo_count;

    logic          reg_write;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd;

    modport master (
        output alu_valid, alu_rd_addr, alu_data,
        output lsu_valid, lsu_rd_addr, lsu_data,
        output q_addr1, q_addr2,
        input  lsu_ready, pend1, pend2, fifo_count,
        input  reg_write, rd_addr, rd
    );

    modport slave (
        input  alu_valid, alu_rd_addr, alu_data,
        input  lsu_valid, lsu_rd_addr, lsu_data,
        input  q_addr1, q_addr2,
        output lsu_ready, pend1, pend2, fifo_count,
        output reg_write, rd_addr, rd
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Writeback arbiter: ALU results win the regfile port; load/mul results wait
// in a small FIFO and drain in ALU-idle cycles. Reports outstanding writes.
module regfile_wb_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic         clk,
    input  logic         rst,
    regfile_wb_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [DEPTH-1:0] slot_vld;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    logic alu_wr_c;
    logic full_c;
    logic empty_c;
    logic push_c;
    logic pop_c;
    logic hit1_c;
    logic hit2_c;

    // Address 0 beats are consumed but never written or queued.
    always_comb begin
        full_c   = (count == CW'(DEPTH));
        empty_c  = (count == CW'(0));
        alu_wr_c = bus.alu_valid && (bus.alu_rd_addr != AW'(0));
        push_c   = bus.lsu_valid && !full_c && (bus.lsu_rd_addr != AW'(0));
        pop_c    = !alu_wr_c && !empty_c;
    end

    assign bus.lsu_ready  = !full_c;
    assign bus.fifo_count = count;

    // Payload storage; validity is tracked separately so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= '{addr: bus.lsu_rd_addr, data: bus.lsu_data};
        end
    end

    // Pointers, occupancy and per-slot valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            slot_vld <= '0;
        end else begin
            if (pop_c) begin
                rd_ptr           <= rd_ptr + PW'(1);
                slot_vld[rd_ptr] <= 1'b0;
            end
            if (push_c) begin
                wr_ptr           <= wr_ptr + PW'(1);
                slot_vld[wr_ptr] <= 1'b1;
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered write port; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (alu_wr_c) begin
            wr_en   <= 1'b1;
            wr_addr <= bus.alu_rd_addr;
            wr_data <= bus.alu_data;
        end else if (pop_c) begin
            wr_en   <= 1'b1;
            wr_addr <= mem[rd_ptr].addr;
            wr_data <= mem[rd_ptr].data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    assign bus.reg_write = wr_en;
    assign bus.rd_addr   = wr_addr;
    assign bus.rd        = wr_data;

    // The output register counts as outstanding: the regfile commits one edge later.
    always_comb begin
        hit1_c = 1'b0;
        hit2_c = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (slot_vld[i] && (mem[i].addr == bus.q_addr1)) hit1_c = 1'b1;
            if (slot_vld[i] && (mem[i].addr == bus.q_addr2)) hit2_c = 1'b1;
        end
        if (wr_en && (wr_addr == bus.q_addr1)) hit1_c = 1'b1;
        if (wr_en && (wr_addr == bus.q_addr2)) hit2_c = 1'b1;
    end

    assign bus.pend1 = (bus.q_addr1 != AW'(0)) && hit1_c;
    assign bus.pend2 = (bus.q_addr2 != AW'(0)) && hit2_c;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: reset, ALU path, load latency/priority,
// backpressure, address 0, hazard flags and mid-operation reset.
module tb_regfile_wb_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    regfile_wb_if #(.DEPTH(4), .AW(5), .DW(32)) bus ();

    regfile_wb_ctrl #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference regfile and a watch on addresses that must never be written.
    logic [31:0] rf [32];
    int          hits = 0;
    always @(posedge clk) begin
        if (bus.reg_write) rf[bus.rd_addr] <= bus.rd;
        if (bus.reg_write && bus.rd_addr >= 5'd20 && bus.rd_addr <= 5'd22) hits <= hits + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.alu_valid = v; bus.alu_rd_addr = a; bus.alu_data = d;
    endtask

    task automatic lsu(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.lsu_valid = v; bus.lsu_rd_addr = a; bus.lsu_data = d;
    endtask

    task automatic wr_chk(input string tag, input logic [4:0] a, input logic [31:0] d);
        check({tag, "_we"}, 64'(bus.reg_write), 64'd1);
        check({tag, "_addr"}, 64'(bus.rd_addr), 64'(a));
        check({tag, "_data"}, 64'(bus.rd), 64'(d));
    endtask

    initial begin
        // Reset while both sources are active.
        rst = 1'b1;
        alu(1'b1, 5'd1, 32'd1);
        lsu(1'b1, 5'd2, 32'd2);
        bus.q_addr1 = 5'd1;
        bus.q_addr2 = 5'd2;
        tick(); tick();
        check("rst_we", 64'(bus.reg_write), 64'd0);
        check("rst_cnt", 64'(bus.fifo_count), 64'd0);
        check("rst_rdy", 64'(bus.lsu_ready), 64'd1);
        check("rst_p1", 64'(bus.pend1), 64'd0);
        check("rst_p2", 64'(bus.pend2), 64'd0);
        check("rst_addr", 64'(bus.rd_addr), 64'd0);
        rst = 1'b0;
        alu(1'b0, 5'd0, 32'd0);
        lsu(1'b0, 5'd0, 32'd0);
        bus.q_addr1 = 5'd0;
        bus.q_addr2 = 5'd0;

        // ALU write, one-cycle latency.
        alu(1'b1, 5'd5, 32'd21);
        tick();
        alu(1'b0, 5'd0, 32'd0);
        wr_chk("alu", 5'd5, 32'd21);
        tick();
        check("alu_idle_we", 64'(bus.reg_write), 64'd0);
        check("alu_hold_addr", 64'(bus.rd_addr), 64'd5);
        check("alu_rf5", 64'(rf[5]), 64'd21);

        // Load path: push at edge N, write after edge N+1.
        lsu(1'b1, 5'd7, 32'hDEADBEEF);
        bus.q_addr1 = 5'd7;
        tick();
        lsu(1'b0, 5'd0, 32'd0);
        check("ld_n_we", 64'(bus.reg_write), 64'd0);
        check("ld_n_cnt", 64'(bus.fifo_count), 64'd1);
        check("ld_n_p1", 64'(bus.pend1), 64'd1);
        tick();
        wr_chk("ld", 5'd7, 32'hDEADBEEF);
        check("ld_cnt", 64'(bus.fifo_count), 64'd0);
        check("ld_p1_out", 64'(bus.pend1), 64'd1);
        tick();
        check("ld_p1_gone", 64'(bus.pend1), 64'd0);
        check("ld_rf7", 64'(rf[7]), 64'hDEADBEEF);
        bus.q_addr1 = 5'd0;

        // Same push under three ALU cycles: ALU retires first.
        lsu(1'b1, 5'd7, 32'h12345678);
        alu(1'b1, 5'd4, 32'd40);
        tick();
        lsu(1'b0, 5'd0, 32'd0);
        wr_chk("pri0", 5'd4, 32'd40);
        alu(1'b1, 5'd4, 32'd41);
        tick();
        wr_chk("pri1", 5'd4, 32'd41);
        check("pri1_cnt", 64'(bus.fifo_count), 64'd1);
        alu(1'b1, 5'd4, 32'd42);
        tick();
        wr_chk("pri2", 5'd4, 32'd42);
        alu(1'b0, 5'd0, 32'd0);
        tick();
        wr_chk("pri_ld", 5'd7, 32'h12345678);
        check("pri_cnt", 64'(bus.fifo_count), 64'd0);

        // Backpressure: ALU holds the port while five beats are offered.
        alu(1'b1, 5'd3, 32'd3);
        for (int i = 0; i < 4; i++) begin
            lsu(1'b1, 5'(10 + i), 32'(32'h100 + 10 + i));
            tick();
        end
        lsu(1'b1, 5'd14, 32'h10E);
        check("bp_rdy", 64'(bus.lsu_ready), 64'd0);
        check("bp_cnt", 64'(bus.fifo_count), 64'd4);
        tick();
        check("bp_cnt_hold", 64'(bus.fifo_count), 64'd4);
        check("bp_alu", 64'(bus.rd_addr), 64'd3);
        alu(1'b0, 5'd0, 32'd0);
        tick();
        wr_chk("bp10", 5'd10, 32'h10A);
        check("bp10_cnt", 64'(bus.fifo_count), 64'd3);
        check("bp10_rdy", 64'(bus.lsu_ready), 64'd1);
        tick();
        lsu(1'b0, 5'd0, 32'd0);
        wr_chk("bp11", 5'd11, 32'h10B);
        check("bp11_cnt", 64'(bus.fifo_count), 64'd3);
        tick();
        wr_chk("bp12", 5'd12, 32'h10C);
        tick();
        wr_chk("bp13", 5'd13, 32'h10D);
        tick();
        wr_chk("bp14", 5'd14, 32'h10E);
        check("bp_empty", 64'(bus.fifo_count), 64'd0);
        tick();
        check("bp_idle", 64'(bus.reg_write), 64'd0);

        // Address 0: ALU to x0 does not block a drain; LSU to x0 is dropped.
        lsu(1'b1, 5'd9, 32'd99);
        tick();
        lsu(1'b0, 5'd0, 32'd0);
        alu(1'b1, 5'd0, 32'd555);
        tick();
        alu(1'b0, 5'd0, 32'd0);
        wr_chk("x0_drain", 5'd9, 32'd99);
        check("x0_cnt", 64'(bus.fifo_count), 64'd0);
        lsu(1'b1, 5'd0, 32'd77);
        check("x0_rdy", 64'(bus.lsu_ready), 64'd1);
        tick();
        lsu(1'b0, 5'd0, 32'd0);
        check("x0_push_cnt", 64'(bus.fifo_count), 64'd0);
        check("x0_push_we", 64'(bus.reg_write), 64'd0);
        tick();
        check("x0_push_we2", 64'(bus.reg_write), 64'd0);

        // Hazard flags through queue, output register, then retired.
        alu(1'b1, 5'd3, 32'd33);
        lsu(1'b1, 5'd12, 32'hC);
        tick();
        lsu(1'b0, 5'd0, 32'd0);
        alu(1'b0, 5'd0, 32'd0);
        bus.q_addr1 = 5'd12;
        bus.q_addr2 = 5'd0;
        #1;
        check("hz_q_p1", 64'(bus.pend1), 64'd1);
        check("hz_q_p2", 64'(bus.pend2), 64'd0);
        bus.q_addr2 = 5'd3;
        #1;
        check("hz_out_p2", 64'(bus.pend2), 64'd1);
        bus.q_addr2 = 5'd0;
        tick();
        wr_chk("hz_wr", 5'd12, 32'hC);
        check("hz_out_p1", 64'(bus.pend1), 64'd1);
        tick();
        check("hz_done_p1", 64'(bus.pend1), 64'd0);

        // Reset with three queued entries: none may ever be written.
        alu(1'b1, 5'd3, 32'd3);
        for (int i = 0; i < 3; i++) begin
            lsu(1'b1, 5'(20 + i), 32'(i));
            tick();
        end
        check("mr_cnt3", 64'(bus.fifo_count), 64'd3);
        bus.q_addr1 = 5'd21;
        #1;
        check("mr_p1_q", 64'(bus.pend1), 64'd1);
        lsu(1'b0, 5'd0, 32'd0);
        alu(1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_cnt", 64'(bus.fifo_count), 64'd0);
        check("mr_we", 64'(bus.reg_write), 64'd0);
        check("mr_rdy", 64'(bus.lsu_ready), 64'd1);
        check("mr_p1", 64'(bus.pend1), 64'd0);
        for (int i = 0; i < 5; i++) tick();
        check("mr_never", 64'(hits), 64'd0);
        check("mr_idle", 64'(bus.reg_write), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
Writeback controller that owns the regfile write port (reg_write, rd_addr, rd) in the RISC-V pipeline. It merges two result sources into the single write port:
- single-cycle ALU results, which have priority;
- long-latency load/multiply results, buffered in a small FIFO with valid/ready backpressure.
It also reports which source registers still have an unretired write, so the hazard unit can stall issue.

Parameters:
DEPTH, 4, FIFO entries for the load/multiply path (power of two, >=2)
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
alu_valid  in  1  ALU result present this cycle; no ready, always accepted
alu_rd_addr  in  AW  ALU destination register
alu_data  in  DW  ALU result
lsu_valid  in  1  load/mul result offered
lsu_ready  out  1  FIFO can accept; equals !full
lsu_rd_addr  in  AW  load/mul destination register
lsu_data  in  DW  load/mul result
q_addr1  in  AW  hazard query address 1 (decode rs1)
q_addr2  in  AW  hazard query address 2 (decode rs2)
pend1  out  1  write to q_addr1 still outstanding
pend2  out  1  write to q_addr2 still outstanding
fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy
reg_write  out  1  regfile write enable (registered)
rd_addr  out  AW  regfile write address (registered)
rd  out  DW  regfile write data (registered)

Behaviour:
- Reset (rst=1 at posedge): reg_write=0, rd_addr=0, rd=0, FIFO empty, fifo_count=0. lsu_ready=1 on the cycle after reset. pend1 and pend2 read 0.
- Reset mid-operation drops all queued entries and any pending output write.
- ALU path has 1-cycle latency. If alu_valid=1 and alu_rd_addr!=0 at edge N, then after edge N: reg_write=1, rd_addr=alu_rd_addr, rd=alu_data.
- Drain: if no qualifying ALU write and the FIFO is non-empty at edge N, pop the head. After edge N, reg_write=1 with the head's addr/data.
- If neither an ALU write nor a drain occurs, reg_write=0 after the edge; rd_addr and rd hold their previous values.
- Push: lsu_valid and lsu_ready at edge N with lsu_rd_addr!=0 pushes {addr,data} at the tail.
- lsu_rd_addr==0: the handshake completes (the beat is consumed) but nothing is written or pushed.
- No FIFO bypass: an entry is popped at the earliest one edge after its push. Minimum load-to-reg_write latency is therefore 2 cycles.
- lsu_ready=!full, computed combinationally from the occupancy. A pop in the same cycle does not make a full FIFO ready.
- Simultaneous push and pop on a non-full FIFO: occupancy is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Full is count==DEPTH; empty is count==0.
- An ALU write never stalls. The FIFO drains only in cycles with no qualifying ALU write, so a continuous ALU stream starves the FIFO. This is intended; the upstream unit sees lsu_ready=0.
- Write order: ALU results may retire before older queued loads to the same register. Correct architectural order is guaranteed only because the hazard unit stalls on pend flags.
- pend1 (combinational) = (q_addr1!=0) AND (any valid FIFO entry has addr==q_addr1, OR (reg_write and rd_addr==q_addr1)). The output-register term exists because the regfile only commits on the edge after reg_write is asserted. pend2 is defined identically on q_addr2.
- The regfile is never written at address 0 through this block.

Test Plan:
- Reset: assert rst 2 cycles while alu_valid=1 and lsu_valid=1 -> reg_write=0, fifo_count=0, lsu_ready=1, pend1=pend2=0.
- ALU write: alu_valid=1, alu_rd_addr=5, alu_data=21 for one cycle -> next cycle reg_write=1, rd_addr=5, rd=21. The regfile then reads 21 at x5, and reg_write=0 the cycle after.
- LSU latency and priority: push lsu_rd_addr=7, lsu_data=0xDEADBEEF at edge N with alu_valid=0 -> reg_write=1 with rd_addr=7 after edge N+1. Repeat the push with alu_valid held for 3 cycles -> the ALU writes appear first, and x7 is written 1 cycle after alu_valid drops.
- Backpressure: hold alu_valid=1 (addr 3), push 5 LSU beats to addrs 10..14 -> lsu_ready=0 after 4 accepted, fifo_count=4. Release ALU -> writes 10,11,12,13 in order, then 14 is accepted and written.
- Address 0: alu_rd_addr=0 with 1 queued entry (addr 9) -> the entry drains that cycle. An LSU push to addr 0 -> fifo_count unchanged, no reg_write.
- Hazard flags: queue addr 12, set q_addr1=12 and q_addr2=0 -> pend1=1, pend2=0. pend1 stays 1 while rd_addr=12 and reg_write=1, then drops to 0 the cycle after. Also apply rst with 3 entries queued -> next cycle fifo_count=0 and none of the three is ever written.
